// File: rtl/priority_encoder.sv
// priority_encoder: registered MSB-first priority encoder with valid flag.
// Optional one-hot grant output enabled by defining PRIO_ENC_GRANT_EN.
module priority_encoder #(
    parameter int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [OUT_W-1:0] Q,
`ifdef PRIO_ENC_GRANT_EN
    output logic             valid,
    output logic [WIDTH-1:0] grant
`else
    output logic             valid
`endif
);
    logic [OUT_W-1:0] idx;
    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) idx = D[i] ? OUT_W'(i) : idx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q     <= '0;
            valid <= 1'b0;
`ifdef PRIO_ENC_GRANT_EN
            grant <= '0;
`endif
        end else begin
            Q     <= idx;
            valid <= |D;
`ifdef PRIO_ENC_GRANT_EN
            grant <= (|D) ? (WIDTH'(1) << idx) : '0;
`endif
        end
    end
endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: random and directed checks of priority_encoder against
// a threshold-based reference model of the highest set bit.
module tb_priority_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d = 8'hFF;
    logic [2:0] q;
    logic       valid;
    int         total = 0;
    int         bad = 0;
    logic [2:0] m_q = '0;
    logic       m_v = 1'b0;
`ifdef PRIO_ENC_GRANT_EN
    logic [7:0] grant;
    logic [7:0] m_g = '0;
`endif

    priority_encoder dut (
        .clk(clk),
        .rst(rst),
        .D(d),
        .Q(q),
`ifdef PRIO_ENC_GRANT_EN
        .valid(valid),
        .grant(grant)
`else
        .valid(valid)
`endif
    );

    always #5 clk = ~clk;

    // Highest set bit = largest i with v >= 2^i.
    function automatic logic [2:0] top_bit(input logic [7:0] v);
        logic [2:0] r = '0;
        for (int i = 0; i < 8; i++) if (int'(v) >= (1 << i)) r = 3'(i);
        return r;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q = '0;
            m_v = 1'b0;
        end else begin
            m_v = (d != 8'h00);
            m_q = top_bit(d);
        end
`ifdef PRIO_ENC_GRANT_EN
        m_g = m_v ? 8'(1 << m_q) : 8'h00;
`endif
    end

    always @(negedge clk) begin
        check("model_q", int'(q), int'(m_q));
        check("model_valid", int'(valid), int'(m_v));
`ifdef PRIO_ENC_GRANT_EN
        check("model_grant", int'(grant), int'(m_g));
`endif
    end

    task automatic step(input logic [7:0] v, input int eq, input int ev);
        d = v;
        @(negedge clk);
        check("lit_q", int'(q), eq);
        check("lit_valid", int'(valid), ev);
`ifdef PRIO_ENC_GRANT_EN
        check("lit_grant", int'(grant), ev ? (1 << eq) : 0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_q", int'(q), 0);
        check("reset_valid", int'(valid), 0);
        rst = 1'b0;
        step(8'b0000_0001, 0, 1);
        step(8'b1010_0110, 7, 1);
        step(8'b0010_0110, 5, 1);
        step(8'h00, 0, 0);
        for (int i = 0; i < 8; i++) step(8'(1 << i), i, 1);
        for (int i = 0; i < 200; i++) begin
            d = 8'($urandom);
            @(negedge clk);
        end
        step(8'h40, 6, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_q", int'(q), 0);
        check("async_rst_valid", int'(valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_q", int'(q), 6);
        check("post_rst_valid", int'(valid), 1);
        step(8'h00, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
